// File: rtl/shift_arbiter_pkg.sv
// Shared constants and types for the shift arbiter slice.
package shift_arbiter_pkg;

  localparam int DATA_W  = 32;
  localparam int SHAMT_W = 5;
  localparam int ID_W    = 2;

  localparam logic SHIFT_OP_SLL = 1'b0;
  localparam logic SHIFT_OP_SRA = 1'b1;

  // Result-register occupancy.
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

endpackage

// File: rtl/shift_arbiter_if.sv
// Request/response bundle between requesters (master) and the arbiter (slave).
interface shift_arbiter_if #(
  parameter int NUM_REQ = 2
);
  import shift_arbiter_pkg::*;

  logic [NUM_REQ-1:0]         req_valid;
  logic [NUM_REQ-1:0]         req_ready;
  logic [DATA_W*NUM_REQ-1:0]  req_data;
  logic [SHAMT_W*NUM_REQ-1:0] req_shamt;
  logic [NUM_REQ-1:0]         req_op;
  logic                       resp_valid;
  logic                       resp_ready;
  logic [DATA_W-1:0]          resp_data;
  logic [ID_W-1:0]            resp_id;

  modport master (
    output req_valid, req_data, req_shamt, req_op, resp_ready,
    input  req_ready, resp_valid, resp_data, resp_id
  );

  modport slave (
    input  req_valid, req_data, req_shamt, req_op, resp_ready,
    output req_ready, resp_valid, resp_data, resp_id
  );

endinterface

// File: rtl/shift_arbiter_rr.sv
// Combinational round-robin grant: first set request at or above ptr, with wrap.
module shift_arbiter_rr
  import shift_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    idx,
  output logic               any
);

  // Scan priority slots k = 0..NUM_REQ-1, slot k maps to requester (ptr + k) mod NUM_REQ.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!any && req[i] && (((int'(ptr) + k) % NUM_REQ) == i)) begin
          any      = 1'b1;
          grant[i] = 1'b1;
          idx      = ID_W'(i);
        end
      end
    end
  end

endmodule

// File: rtl/shift_arbiter.sv
// Shares one sll/sra datapath between NUM_REQ requesters with a one-deep result register.
//
//   state    | meaning
//   ---------+--------------------------------------------------
//   ST_EMPTY | result register empty, resp_valid = 0
//   ST_FULL  | result register holds a result, resp_valid = 1
module shift_arbiter
  import shift_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic           clock,
  input  logic           reset,
  shift_arbiter_if.slave bus
);

  state_t              state;
  logic [ID_W-1:0]     rr_ptr;
  logic [DATA_W-1:0]   resp_data_q;
  logic [ID_W-1:0]     resp_id_q;

  logic                can_accept;
  logic [NUM_REQ-1:0]  arb_req;
  logic [NUM_REQ-1:0]  grant;
  logic [ID_W-1:0]     gnt_idx;
  logic                gnt_any;
  logic [ID_W-1:0]     ptr_next;

  logic [DATA_W-1:0]   data_sel;
  logic [SHAMT_W-1:0]  shamt_sel;
  logic                op_sel;
  logic [DATA_W-1:0]   sll_res;
  logic [DATA_W-1:0]   sra_res;
  logic [DATA_W-1:0]   result;

  // The slot frees up in the same cycle the consumer takes the current result.
  assign can_accept = (state == ST_EMPTY) || bus.resp_ready;
  assign arb_req    = (can_accept && !reset) ? bus.req_valid : '0;

  shift_arbiter_rr #(
    .NUM_REQ (NUM_REQ)
  ) u_rr (
    .req   (arb_req),
    .ptr   (rr_ptr),
    .grant (grant),
    .idx   (gnt_idx),
    .any   (gnt_any)
  );

  assign bus.req_ready = grant;
  assign ptr_next      = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;

  // Operand mux selected by the granted index.
  always_comb begin
    data_sel  = '0;
    shamt_sel = '0;
    op_sel    = SHIFT_OP_SLL;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_idx == ID_W'(i)) begin
        data_sel  = bus.req_data[DATA_W*i +: DATA_W];
        shamt_sel = bus.req_shamt[SHAMT_W*i +: SHAMT_W];
        op_sel    = bus.req_op[i];
      end
    end
  end

  assign sll_res = data_sel << shamt_sel;
  assign sra_res = $unsigned($signed(data_sel) >>> shamt_sel);
  assign result  = (op_sel == SHIFT_OP_SRA) ? sra_res : sll_res;

  // Occupancy FSM, result register and round-robin pointer.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= ST_EMPTY;
      resp_data_q <= '0;
      resp_id_q   <= '0;
      rr_ptr      <= '0;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (gnt_any) begin
            resp_data_q <= result;
            resp_id_q   <= gnt_idx;
            rr_ptr      <= ptr_next;
            state       <= ST_FULL;
          end
        end
        ST_FULL: begin
          if (gnt_any) begin
            resp_data_q <= result;
            resp_id_q   <= gnt_idx;
            rr_ptr      <= ptr_next;
          end else if (bus.resp_ready) begin
            state <= ST_EMPTY;
          end
        end
        default: state <= ST_EMPTY;
      endcase
    end
  end

  assign bus.resp_valid = (state == ST_FULL);
  assign bus.resp_data  = resp_data_q;
  assign bus.resp_id    = resp_id_q;

endmodule

// File: tb/tb_shift_arbiter.sv
// Self-checking bench for shift_arbiter: directed scenarios plus a scoreboard monitor.
module tb_shift_arbiter;

  localparam int N = 2;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  id;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;

  int n_checks = 0;
  int n_pass   = 0;
  int n_push   = 0;
  int n_pop    = 0;

  exp_t sb[$];
  exp_t e;

  // Monitor-side reference model state.
  logic         m_full = 1'b0;
  int           m_ptr  = 0;
  int           exp_g;
  int           jj;
  logic [N-1:0] exp_rdy;

  shift_arbiter_if #(.NUM_REQ(N)) bus ();

  shift_arbiter #(.NUM_REQ(N)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] ref_shift(input logic [31:0] d, input logic [4:0] s,
                                            input logic op);
    logic [31:0] r;
    if (op) begin
      r = d >> s;
      if (d[31]) r = r | ~(32'hFFFF_FFFF >> s);
    end else begin
      r = d << s;
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_req(input int i, input logic [31:0] d, input logic [4:0] s,
                         input logic op);
    bus.req_data[32*i +: 32] = d;
    bus.req_shamt[5*i +: 5]  = s;
    bus.req_op[i]            = op;
  endtask

  // Scoreboard monitor: predicts grants, pushes expected results on request
  // handshakes and pops/compares on response handshakes.
  always @(negedge clock) begin
    exp_rdy = '0;
    exp_g   = -1;
    if (!reset && (!m_full || bus.resp_ready)) begin
      for (int k = 0; k < N; k++) begin
        jj = (m_ptr + k) % N;
        if (exp_g < 0 && bus.req_valid[jj]) begin
          exp_g       = jj;
          exp_rdy[jj] = 1'b1;
        end
      end
    end

    n_checks++;
    if (bus.resp_valid !== m_full)
      $display("FAIL mon_resp_valid: got %b want %b at %0t", bus.resp_valid, m_full, $time);
    else n_pass++;

    n_checks++;
    if (bus.req_ready !== exp_rdy)
      $display("FAIL mon_req_ready: got %b want %b at %0t", bus.req_ready, exp_rdy, $time);
    else n_pass++;

    if (!reset && m_full && bus.resp_ready) begin
      n_checks++;
      if (sb.size() == 0) begin
        $display("FAIL sb_underflow: got response id=%0d with empty scoreboard at %0t",
                 bus.resp_id, $time);
      end else begin
        e = sb.pop_front();
        n_pop++;
        if (bus.resp_data !== e.data || bus.resp_id !== e.id)
          $display("FAIL sb_result: got data=%h id=%0d want data=%h id=%0d at %0t",
                   bus.resp_data, bus.resp_id, e.data, e.id, $time);
        else n_pass++;
      end
    end

    if (!reset && exp_g >= 0) begin
      e.data = ref_shift(bus.req_data[32*exp_g +: 32], bus.req_shamt[5*exp_g +: 5],
                         bus.req_op[exp_g]);
      e.id   = 2'(exp_g);
      sb.push_back(e);
      n_push++;
    end

    if (reset) begin
      m_full = 1'b0;
      m_ptr  = 0;
      sb.delete();
    end else if (exp_g >= 0) begin
      m_full = 1'b1;
      m_ptr  = (exp_g + 1) % N;
    end else if (bus.resp_ready) begin
      m_full = 1'b0;
    end
  end

  task automatic test_reset();
    reset          = 1'b1;
    bus.req_valid  = 2'b11;
    bus.resp_ready = 1'b0;
    set_req(0, 32'h1, 5'd1, 1'b0);
    set_req(1, 32'h2, 5'd1, 1'b0);
    repeat (2) tick();
    n_checks++;
    if (bus.resp_valid !== 1'b0 || bus.resp_data !== 32'h0 || bus.resp_id !== 2'd0)
      $display("FAIL reset_outputs: got valid=%b data=%h id=%0d want 0/0/0",
               bus.resp_valid, bus.resp_data, bus.resp_id);
    else n_pass++;
    @(negedge clock);
    n_checks++;
    if (bus.req_ready !== 2'b00)
      $display("FAIL reset_req_ready: got %b want 00", bus.req_ready);
    else n_pass++;
    tick();
    bus.req_valid = '0;
    reset         = 1'b0;
    tick();
  endtask

  task automatic test_single_sra();
    bus.resp_ready = 1'b1;
    set_req(0, 32'h8000_0000, 5'd4, 1'b1);
    bus.req_valid = 2'b01;
    @(negedge clock);
    n_checks++;
    if (bus.req_ready !== 2'b01) $display("FAIL sra_grant: got %b want 01", bus.req_ready);
    else n_pass++;
    tick();
    bus.req_valid = '0;
    n_checks++;
    if (bus.resp_valid !== 1'b1 || bus.resp_data !== 32'hF800_0000 || bus.resp_id !== 2'd0)
      $display("FAIL sra_result: got valid=%b data=%h id=%0d want 1/f8000000/0",
               bus.resp_valid, bus.resp_data, bus.resp_id);
    else n_pass++;
    tick();
  endtask

  task automatic test_sll_edge();
    bus.resp_ready = 1'b1;
    set_req(1, 32'h0000_0001, 5'd31, 1'b0);
    bus.req_valid = 2'b10;
    tick();
    bus.req_valid = '0;
    n_checks++;
    if (bus.resp_valid !== 1'b1 || bus.resp_data !== 32'h8000_0000 || bus.resp_id !== 2'd1)
      $display("FAIL sll31_result: got valid=%b data=%h id=%0d want 1/80000000/1",
               bus.resp_valid, bus.resp_data, bus.resp_id);
    else n_pass++;
    for (int op = 0; op < 2; op++) begin
      set_req(0, 32'h1234_ABCD, 5'd0, op[0]);
      bus.req_valid = 2'b01;
      tick();
      n_checks++;
      if (bus.resp_valid !== 1'b1 || bus.resp_data !== 32'h1234_ABCD || bus.resp_id !== 2'd0)
        $display("FAIL shamt0_op%0d: got valid=%b data=%h id=%0d want 1/1234abcd/0",
                 op, bus.resp_valid, bus.resp_data, bus.resp_id);
      else n_pass++;
    end
    bus.req_valid = '0;
    tick();
  endtask

  task automatic test_contention();
    logic [1:0] want;
    reset = 1'b1;
    tick();
    reset          = 1'b0;
    bus.resp_ready = 1'b1;
    set_req(0, 32'h0000_0011, 5'd1, 1'b0);
    set_req(1, 32'hF000_0000, 5'd2, 1'b1);
    bus.req_valid = 2'b11;
    for (int c = 0; c < 4; c++) begin
      want = (c % 2 == 0) ? 2'b01 : 2'b10;
      @(negedge clock);
      n_checks++;
      if (bus.req_ready !== want)
        $display("FAIL contention_grant%0d: got %b want %b", c, bus.req_ready, want);
      else n_pass++;
      tick();
      n_checks++;
      if (bus.resp_valid !== 1'b1 || bus.resp_id !== 2'(c % 2))
        $display("FAIL contention_resp%0d: got valid=%b id=%0d want 1/%0d",
                 c, bus.resp_valid, bus.resp_id, c % 2);
      else n_pass++;
    end
    bus.req_valid = '0;
    tick();
  endtask

  task automatic test_backpressure();
    bus.resp_ready = 1'b0;
    set_req(0, 32'h0000_00F0, 5'd4, 1'b0);
    bus.req_valid = 2'b01;
    tick();
    set_req(0, 32'hA5A5_A5A5, 5'd8, 1'b1);
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      n_checks++;
      if (bus.req_ready !== 2'b00 || bus.resp_valid !== 1'b1 ||
          bus.resp_data !== 32'h0000_0F00 || bus.resp_id !== 2'd0)
        $display("FAIL stall%0d: got rdy=%b valid=%b data=%h id=%0d want 00/1/00000f00/0",
                 c, bus.req_ready, bus.resp_valid, bus.resp_data, bus.resp_id);
      else n_pass++;
      tick();
    end
    bus.resp_ready = 1'b1;
    @(negedge clock);
    n_checks++;
    if (bus.req_ready !== 2'b01) $display("FAIL release_grant: got %b want 01", bus.req_ready);
    else n_pass++;
    tick();
    bus.req_valid = '0;
    n_checks++;
    if (bus.resp_valid !== 1'b1 || bus.resp_data !== 32'hFFA5_A5A5 || bus.resp_id !== 2'd0)
      $display("FAIL release_result: got valid=%b data=%h id=%0d want 1/ffa5a5a5/0",
               bus.resp_valid, bus.resp_data, bus.resp_id);
    else n_pass++;
    tick();
  endtask

  task automatic test_reset_mid();
    bus.resp_ready = 1'b0;
    set_req(1, 32'h0000_0003, 5'd1, 1'b0);
    bus.req_valid = 2'b10;
    tick();
    set_req(0, 32'h0000_0005, 5'd2, 1'b0);
    bus.req_valid = 2'b11;
    reset         = 1'b1;
    @(negedge clock);
    n_checks++;
    if (bus.req_ready !== 2'b00) $display("FAIL midreset_ready: got %b want 00", bus.req_ready);
    else n_pass++;
    tick();
    n_checks++;
    if (bus.resp_valid !== 1'b0) $display("FAIL midreset_valid: got %b want 0", bus.resp_valid);
    else n_pass++;
    reset          = 1'b0;
    bus.resp_ready = 1'b1;
    @(negedge clock);
    n_checks++;
    if (bus.req_ready !== 2'b01) $display("FAIL midreset_first_grant: got %b want 01", bus.req_ready);
    else n_pass++;
    tick();
    bus.req_valid = '0;
    n_checks++;
    if (bus.resp_id !== 2'd0 || bus.resp_data !== 32'h0000_0014)
      $display("FAIL midreset_result: got data=%h id=%0d want 00000014/0",
               bus.resp_data, bus.resp_id);
    else n_pass++;
    tick();
  endtask

  task automatic test_random();
    logic [N-1:0] hs;
    int push0;
    int pop0;
    push0 = n_push;
    pop0  = n_pop;
    for (int c = 0; c < 10000; c++) begin
      @(negedge clock);
      hs = bus.req_valid & bus.req_ready;
      @(posedge clock);
      #1;
      for (int i = 0; i < N; i++) begin
        if (!bus.req_valid[i] || hs[i]) begin
          bus.req_valid[i] = ($urandom_range(0, 3) != 0);
          set_req(i, $urandom(), 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
        end
      end
      bus.resp_ready = ($urandom_range(0, 3) != 0);
    end
    bus.req_valid  = '0;
    bus.resp_ready = 1'b1;
    repeat (3) tick();
    n_checks++;
    if (sb.size() != 0 || (n_push - push0) != (n_pop - pop0))
      $display("FAIL random_drain: got %0d pending, pushed %0d popped %0d want 0 pending",
               sb.size(), n_push - push0, n_pop - pop0);
    else n_pass++;
    n_checks++;
    if ((n_push - push0) < 1000)
      $display("FAIL random_traffic: got %0d results want at least 1000", n_push - push0);
    else n_pass++;
  endtask

  initial begin
    bus.req_valid  = '0;
    bus.req_data   = '0;
    bus.req_shamt  = '0;
    bus.req_op     = '0;
    bus.resp_ready = 1'b0;
    test_reset();
    test_single_sra();
    test_sll_edge();
    test_contention();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
